alarm_sequencer: RTL



---
 rtl/alarm_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alarm_sequencer.sv
// ============================================================================
// alarm_sequencer : wall-clock alarm FSM (arm, ring, snooze, timeout, buzzer)
// Option macro    : ALARM_SNOOZE_EN enables the snooze state and snz_cnt
// Revision        : 1.0
// ============================================================================
`default_nettype none

module alarm_sequencer #(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int TONE_DIV       = 3500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  input  logic [3:0] al_hours,
  input  logic [5:0] al_minutes,
  input  logic       toggle_pulse,
  input  logic       snooze_pulse,
  output logic [1:0] state,
  output logic       al_on,
  output logic       ringing,
  output logic       buzzer
);

  typedef enum logic [1:0] {
    S_OFF     = 2'd0,
    S_ARMED   = 2'd1,
    S_RINGING = 2'd2,
    S_SNOOZE  = 2'd3
  } state_t;

  localparam int RW = $clog2(RING_TIMEOUT_S + 1);
  localparam int TW = $clog2(TONE_DIV);

  state_t        cur;
  state_t        nxt;
  logic          match;
  logic          match_q;
  logic          trigger;
  logic [RW-1:0] ring_cnt;
  logic [TW-1:0] tone_cnt;
  logic          tone;
  logic          beat;
  logic          ring_timeout;
  logic          snooze_req;
  logic          snz_expire;

  assign match        = (hours == al_hours) && (minutes == al_minutes);
  assign trigger      = match && !match_q;
  assign ring_timeout = sec_tick && (ring_cnt == RW'(RING_TIMEOUT_S - 1));
  assign state        = cur;

`ifdef ALARM_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_MIN * 60 + 1);

  logic [SW-1:0] snz_cnt;

  assign snooze_req = snooze_pulse;
  assign snz_expire = sec_tick && (snz_cnt == SW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snz_cnt <= '0;
    end else if (cur == S_RINGING && nxt == S_SNOOZE) begin
      snz_cnt <= SW'(SNOOZE_MIN * 60);
    end else if (cur == S_SNOOZE && sec_tick && snz_cnt != '0) begin
      snz_cnt <= snz_cnt - 1'b1;
    end
  end
`else
  logic unused_snooze;

  assign unused_snooze = snooze_pulse;
  assign snooze_req    = 1'b0;
  assign snz_expire    = 1'b0;
`endif

  // Priority: toggle > snooze > second-tick transitions > trigger
  always_comb begin
    nxt = cur;
    case (cur)
      S_OFF: begin
        if (toggle_pulse) nxt = S_ARMED;
      end
      S_ARMED: begin
        if (toggle_pulse)  nxt = S_OFF;
        else if (trigger)  nxt = S_RINGING;
      end
      S_RINGING: begin
        if (toggle_pulse)      nxt = S_OFF;
        else if (snooze_req)   nxt = S_SNOOZE;
        else if (ring_timeout) nxt = S_ARMED;
      end
      S_SNOOZE: begin
        if (toggle_pulse)    nxt = S_OFF;
        else if (snz_expire) nxt = S_RINGING;
      end
      default: nxt = S_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur      <= S_OFF;
      al_on    <= 1'b0;
      ringing  <= 1'b0;
      buzzer   <= 1'b0;
      match_q  <= 1'b0;
      ring_cnt <= '0;
      tone_cnt <= '0;
      tone     <= 1'b0;
      beat     <= 1'b0;
    end else begin
      cur     <= nxt;
      al_on   <= (nxt != S_OFF);
      ringing <= (nxt == S_RINGING);
      match_q <= match;
      // Gated by the next state too, so the buzzer never outlives RINGING
      buzzer  <= (cur == S_RINGING) && (nxt == S_RINGING) && beat && tone;
      if (nxt != S_RINGING) begin
        ring_cnt <= '0;
        tone_cnt <= '0;
        tone     <= 1'b0;
        beat     <= 1'b0;
      end else if (cur != S_RINGING) begin
        ring_cnt <= '0;
        tone_cnt <= '0;
        tone     <= 1'b0;
        beat     <= 1'b1;
      end else begin
        if (sec_tick) begin
          ring_cnt <= ring_cnt + 1'b1;
          beat     <= ~beat;
        end
        if (tone_cnt == TW'(TONE_DIV - 1)) begin
          tone_cnt <= '0;
          tone     <= ~tone;
        end else begin
          tone_cnt <= tone_cnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
